reverb_param_ramp_bank: RTL
===========================

# reverb_param_ramp_bank

Parametrised multi-channel Avalon-MM parameter register bank for the reverb datapath: next generation of the single-channel PIO registers (damping, decay, mix). The Nios/HPS writes a target per channel; on every audio sample tick the block slews each channel's output toward its target by a fixed step, removing zipper noise on parameter changes. Outputs feed the reverb core directly as a flattened bus.

## Interface
- NUM_CH, 4: number of parameter channels (1..8)
- DATA_W, 24: channel width, unsigned (1..32)
- ADDR_W, 4: Avalon word-address width; requires 2^ADDR_W >= 2*NUM_CH+1
- STEP, 4096: slew step per sample tick, unsigned, >= 1, < 2^DATA_W
- RESET_VAL, 0: reset value of every target and output channel
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [DATA_W-1:0] used
- readdata  out  32  read data, zero-extended, zero wait states
- sample_tick  in  1  one-cycle pulse per audio sample
- out_port  out  NUM_CH*DATA_W  current values; channel i at [i*DATA_W +: DATA_W]
- ramp_busy  out  NUM_CH  bit i high while current[i] != target[i]

## Operation
- Register map (word addresses): 0..NUM_CH-1 target[i] R/W; NUM_CH..2*NUM_CH-1 current[i] RO; 2*NUM_CH status RO: bits [NUM_CH-1:0] = ramp_busy, bit 31 = overrun sticky; writing any value to status clears overrun. Other addresses read 0, writes ignored.
- Write accepted when chipselect && !write_n; target[i] <= writedata[DATA_W-1:0].
- Sweep FSM: IDLE, SWEEP. IDLE + sample_tick -> SWEEP, ch_idx=0. SWEEP: update channel ch_idx, increment; after ch_idx==NUM_CH-1 -> IDLE.
- Channel update: d = target - current (unsigned compare). If |d| <= STEP, current <= target; else current <= current ± STEP toward target. Never overshoots; no wrap.
- sample_tick while in SWEEP (including the last SWEEP cycle): ignored, overrun <= 1.
- Target written during a sweep: channel already visited uses new target on next tick; channel not yet visited uses new target this sweep. Write and update of same channel in same cycle: update uses old target; new target stored.
- Reset: targets, currents = RESET_VAL; FSM IDLE; ch_idx 0; overrun 0; ramp_busy 0; readdata reflects reset registers.

## Timing
- readdata combinational from address and registers (read latency 0).
- target visible on readdata the cycle after the write edge.
- Channel i updates on the (i+1)-th clock edge after the edge sampling sample_tick; sweep takes NUM_CH cycles; minimum tick spacing NUM_CH+1 cycles for no overrun.
- out_port, ramp_busy registered/derived from registers, glitch-free relative to clk.
- Reset mid-sweep: next cycle is IDLE with all values at RESET_VAL; pending sweep abandoned.

## Configuration
- PARAM_RAMP_EN defined: slewing behaviour as above.
- Not defined: write to target[i] also sets current[i] on the same edge (classic PIO behaviour, out_port updates one cycle after write); sample_tick ignored; FSM absent; ramp_busy and overrun constant 0; current addresses still readable.

## Structure
- Package reverb_param_pkg: FSM state enum (IDLE, SWEEP), register offset constants/functions (target base 0, current base NUM_CH, status 2*NUM_CH), status bit position OVERRUN_BIT=31.
- Sub-module param_ramp_step: combinational next-value calculator (current, target, STEP -> next), one instance muxed by ch_idx.

## Test plan
- Reset, then read all addresses -> targets/currents = RESET_VAL, status = 0, out_port all RESET_VAL.
- Write target[1]=0x00A000 from 0, tick 3 times (spacing 8 cycles) -> current[1] = 0x1000, 0x2000, 0x3000; busy bit1 high; after 10 ticks current=0x00A000, busy low.
- Write target[0]=0x001800 from 0x002000 with STEP=4096 -> one tick lands exactly 0x001800, no overshoot.
- Two ticks 2 cycles apart (NUM_CH=4) -> second ignored, status bit31=1; write status -> bit31=0.
- Write target[2] in same cycle SWEEP updates channel 2 -> channel 2 steps toward old target; new target used on next tick.
- Build without PARAM_RAMP_EN: write target[3]=0x123456 -> out_port ch3 = 0x123456 next cycle, ticks have no effect, busy 0.

Source files
------------

// File: rtl/reverb_param_pkg.sv
// Shared definitions for the reverb parameter ramp bank: sweep FSM states,
// register map offsets and status bit positions.
// Offsets that depend on the channel count are provided as functions.
package reverb_param_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

  localparam int TARGET_BASE = 0;
  localparam int OVERRUN_BIT = 31;

  // First current[] word address; currents follow the targets.
  function automatic int current_base(input int num_ch);
    return num_ch;
  endfunction

  // Status word sits directly after the current[] block.
  function automatic int status_addr(input int num_ch);
    return 2 * num_ch;
  endfunction

endpackage

// File: rtl/param_ramp_step.sv
// Next-value calculator for one slewing channel: moves current toward target
// by at most STEP, landing exactly on target when within one step.
// Purely combinational; never overshoots and never wraps.
module param_ramp_step #(
  parameter int          DATA_W = 24,
  parameter int unsigned STEP   = 4096
) (
  input  logic [DATA_W-1:0] current,
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] nxt
);

  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  logic [DATA_W-1:0] diff_up;
  logic [DATA_W-1:0] diff_dn;

  assign diff_up = target - current;
  assign diff_dn = current - target;

  // Step toward target; the add/subtract only happens when the gap exceeds
  // STEP, so the result cannot pass the target or leave the unsigned range.
  always_comb begin
    nxt = current;
    if (target >= current) begin
      if (diff_up <= STEP_V) nxt = target;
      else                   nxt = current + STEP_V;
    end else begin
      if (diff_dn <= STEP_V) nxt = target;
      else                   nxt = current - STEP_V;
    end
  end

endmodule

// File: rtl/reverb_param_ramp_bank.sv
// Multi-channel Avalon-MM parameter bank feeding the reverb core; with
// PARAM_RAMP_EN defined, outputs slew toward targets one channel per cycle after
// each sample tick, otherwise a write sets the output directly (classic PIO).
module reverb_param_ramp_bank
  import reverb_param_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = 24,
  parameter int          ADDR_W    = 4,
  parameter int unsigned STEP      = 4096,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     sample_tick,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic [NUM_CH-1:0]        ramp_busy
);

  localparam int CUR_BASE  = current_base(NUM_CH);
  localparam int STAT_ADDR = status_addr(NUM_CH);
  localparam logic [DATA_W-1:0] RST_V = RESET_VAL[DATA_W-1:0];

  logic [DATA_W-1:0] tgt_q [NUM_CH];
  logic [DATA_W-1:0] cur_q [NUM_CH];
  logic              overrun_q;
  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
  int                addr_i;
  logic              unused_sig;

  assign wr_en      = chipselect && !write_n;
  assign wr_val     = writedata[DATA_W-1:0];
  assign addr_i     = int'(address);
  assign unused_sig = ^{writedata, sample_tick};

  // Target registers: host writes land here in both build flavours.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) tgt_q[i] <= RST_V;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en && addr_i == TARGET_BASE + i) tgt_q[i] <= wr_val;
    end
  end

`ifdef PARAM_RAMP_EN
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sweep_state_t      state_q;
  logic [CH_W-1:0]   ch_idx_q;
  logic [DATA_W-1:0] sel_cur;
  logic [DATA_W-1:0] sel_tgt;
  logic [DATA_W-1:0] step_nxt;

  // Route the channel being visited into the shared step calculator.
  always_comb begin
    sel_cur = cur_q[0];
    sel_tgt = tgt_q[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx_q == CH_W'(i)) begin
        sel_cur = cur_q[i];
        sel_tgt = tgt_q[i];
      end
    end
  end

  param_ramp_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) u_step (
    .current (sel_cur),
    .target  (sel_tgt),
    .nxt     (step_nxt)
  );

  // Sweep FSM: one channel per cycle after a tick; ticks arriving mid-sweep
  // are dropped and flagged. The step reads the pre-edge target, so a write
  // to the channel being visited only takes effect on the following tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_idx_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cur_q[i] <= RST_V;
    end else begin
      if (wr_en && addr_i == STAT_ADDR) overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            state_q  <= SWEEP;
            ch_idx_q <= '0;
          end
        end
        SWEEP: begin
          if (sample_tick) overrun_q <= 1'b1;
          for (int i = 0; i < NUM_CH; i++)
            if (ch_idx_q == CH_W'(i)) cur_q[i] <= step_nxt;
          if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
            state_q  <= IDLE;
            ch_idx_q <= '0;
          end else begin
            ch_idx_q <= ch_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A channel is busy until its output has reached the stored target.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ramp_busy[i] = (cur_q[i] != tgt_q[i]);
  end
`else
  // Without slewing a target write drives the output on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cur_q[i] <= RST_V;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en && addr_i == TARGET_BASE + i) cur_q[i] <= wr_val;
    end
  end

  assign overrun_q = 1'b0;
  assign ramp_busy = '0;
`endif

  // Zero-wait-state read mux; unmapped addresses return zero.
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_i == TARGET_BASE + i) readdata[DATA_W-1:0] = tgt_q[i];
      if (addr_i == CUR_BASE + i)    readdata[DATA_W-1:0] = cur_q[i];
    end
    if (addr_i == STAT_ADDR) begin
      readdata[NUM_CH-1:0]    = ramp_busy;
      readdata[OVERRUN_BIT]   = overrun_q;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = cur_q[g];
  end

endmodule
